// File: rtl/commit_freelist.sv
// commit_freelist: committed rename table plus circular free list serving rename-stage allocation.
// Optional feature macro FREELIST_ROLLBACK_EN adds flush, which rewinds the allocation head to commit_head.
module commit_freelist #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int PHYS_REGS      = 64,
  parameter int ARCH_REGS      = 32,
  localparam int PW            = $clog2(PHYS_REGS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DISPATCH_WIDTH-1:0]          commit_en,
  input  logic [DISPATCH_WIDTH-1:0][4:0]     commit_arch_rd,
  input  logic [DISPATCH_WIDTH-1:0][PW-1:0]  commit_phys_rd,
  input  logic [DISPATCH_WIDTH-1:0]          alloc_req,
  output logic                               alloc_ready,
  output logic [DISPATCH_WIDTH-1:0][PW-1:0]  alloc_phys_rd,
  output logic [PW:0]                        free_count
`ifdef FREELIST_ROLLBACK_EN
  ,
  input  logic                               flush
`endif
);

  localparam int          FREE0 = PHYS_REGS - ARCH_REGS;
  localparam logic [PW:0] ONE   = (PW+1)'(1);

  logic [PW-1:0] crat_q [ARCH_REGS];
  logic [PW-1:0] crat_d [ARCH_REGS];
  logic [PW-1:0] fl_q   [PHYS_REGS];
  logic [PW-1:0] fl_d   [PHYS_REGS];
  logic [PW:0]   head_q, head_d, tail_q, tail_d;
  logic [PW:0]   req_cnt, free_cnt;

  assign free_count = tail_q - head_q;

  // Requesting lanes are compacted: the k-th requester reads slot head+k.
  always_comb begin
    req_cnt       = '0;
    alloc_phys_rd = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      if (alloc_req[l]) begin
        alloc_phys_rd[l] = fl_q[PW'(head_q + req_cnt)];
        req_cnt          = req_cnt + ONE;
      end
    end
  end

`ifdef FREELIST_ROLLBACK_EN
  assign alloc_ready = !flush && (free_count >= req_cnt);
`else
  assign alloc_ready = (free_count >= req_cnt);
`endif

  // Lanes are walked oldest first on a working copy of the table, so a younger lane
  // writing the same arch_rd frees the mapping the older lane just installed.
  always_comb begin
    crat_d   = crat_q;
    fl_d     = fl_q;
    free_cnt = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      if (commit_en[l] && (commit_arch_rd[l] != 5'd0)) begin
        fl_d[PW'(tail_q + free_cnt)] = crat_d[commit_arch_rd[l]];
        crat_d[commit_arch_rd[l]]    = commit_phys_rd[l];
        free_cnt                     = free_cnt + ONE;
      end
    end
    tail_d = tail_q + free_cnt;
  end

`ifdef FREELIST_ROLLBACK_EN
  logic [PW:0] chead_q, chead_d;

  assign chead_d = chead_q + free_cnt;
  assign head_d  = flush ? chead_d : (alloc_ready ? head_q + req_cnt : head_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chead_q <= '0;
    else      chead_q <= chead_d;
  end
`else
  assign head_d = alloc_ready ? head_q + req_cnt : head_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARCH_REGS; i++) crat_q[i] <= PW'(i);
      for (int i = 0; i < PHYS_REGS; i++) fl_q[i] <= (i < FREE0) ? PW'(ARCH_REGS + i) : '0;
      head_q <= '0;
      tail_q <= (PW+1)'(FREE0);
    end else begin
      crat_q <= crat_d;
      fl_q   <= fl_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

`ifndef SYNTHESIS
  // More free entries than non-architectural registers means a register was freed twice.
  always @(posedge clk) begin
    if (rst) assert (free_count <= (PW+1)'(FREE0));
  end
`endif

endmodule

// File: tb/tb_commit_freelist.sv
// Bench for commit_freelist: hand-built vector table, directed drain/reset sequences and a
// queue-model random phase; defining FREELIST_ROLLBACK_EN also exercises flush.
module tb_commit_freelist;
  localparam int PW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        commit_en, alloc_req;
  logic [1:0][4:0]   commit_arch_rd;
  logic [1:0][PW-1:0] commit_phys_rd, alloc_phys_rd;
  logic              alloc_ready;
  logic [PW:0]       free_count;
`ifdef FREELIST_ROLLBACK_EN
  logic              flush;
`endif

  always #5 clk = ~clk;

  commit_freelist dut (
    .clk            (clk),
    .rst            (rst),
    .commit_en      (commit_en),
    .commit_arch_rd (commit_arch_rd),
    .commit_phys_rd (commit_phys_rd),
    .alloc_req      (alloc_req),
    .alloc_ready    (alloc_ready),
    .alloc_phys_rd  (alloc_phys_rd),
    .free_count     (free_count)
`ifdef FREELIST_ROLLBACK_EN
    ,
    .flush          (flush)
`endif
  );

  typedef struct {
    logic [1:0] req; logic [1:0] cen;
    logic [4:0] ar0; logic [5:0] pr0; logic [4:0] ar1; logic [5:0] pr1;
    logic fl; logic rdy; logic [5:0] a0; logic [5:0] a1; int fc;
  } vec_t;

  typedef struct { string name; logic rdy; logic [5:0] a0; logic [5:0] a1; int fc; } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model for the random phase: free list as a FIFO, plus allocated-but-uncommitted regs.
  int fl_m[$];
  int infl_m[$];
  int crat_m[32];

  task automatic model_reset();
    fl_m.delete();
    infl_m.delete();
    for (int i = 0; i < 32; i++) begin
      fl_m.push_back(32 + i);
      crat_m[i] = i;
    end
  endtask

  // Called at a negedge; drives, checks #1 later, returns at the next negedge.
  task automatic run_vec(input vec_t v, input string nm);
    exp_t e, got;
    alloc_req         = v.req;
    commit_en         = v.cen;
    commit_arch_rd[0] = v.ar0;
    commit_phys_rd[0] = v.pr0;
    commit_arch_rd[1] = v.ar1;
    commit_phys_rd[1] = v.pr1;
`ifdef FREELIST_ROLLBACK_EN
    flush             = v.fl;
`endif
    e.name = nm; e.rdy = v.rdy; e.a0 = v.a0; e.a1 = v.a1; e.fc = v.fc;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    n_vec++;
    if (alloc_ready !== got.rdy || free_count !== (PW+1)'(got.fc) ||
        (got.rdy && (alloc_phys_rd[0] !== got.a0 || alloc_phys_rd[1] !== got.a1))) begin
      n_bad++;
      $display("FAIL %s: got ready=%0d a0=%0d a1=%0d count=%0d, want ready=%0d a0=%0d a1=%0d count=%0d",
               got.name, alloc_ready, alloc_phys_rd[0], alloc_phys_rd[1], free_count,
               got.rdy, got.a0, got.a1, got.fc);
    end
    @(negedge clk);
  endtask

  function automatic vec_t idle(input logic [1:0] req, input logic rdy,
                                input logic [5:0] a0, input logic [5:0] a1, input int fc);
    vec_t v;
    v = '{req, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b0, rdy, a0, a1, fc};
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t tbl[8];

  initial begin
    // req, cen, ar0, pr0, ar1, pr1, flush, ready, a0, a1, free_count (sampled before the edge)
    tbl[0] = '{2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b0, 1'b1, 6'd0,  6'd0,  32};
    tbl[1] = '{2'b11, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b0, 1'b1, 6'd32, 6'd33, 32};
    tbl[2] = '{2'b10, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b0, 1'b1, 6'd0,  6'd34, 30};
    tbl[3] = '{2'b01, 2'b01, 5'd5, 6'd32, 5'd0, 6'd0,  1'b0, 1'b1, 6'd35, 6'd0,  29};
    tbl[4] = '{2'b00, 2'b11, 5'd7, 6'd33, 5'd7, 6'd34, 1'b0, 1'b1, 6'd0,  6'd0,  29};
    tbl[5] = '{2'b00, 2'b01, 5'd0, 6'd35, 5'd0, 6'd0,  1'b0, 1'b1, 6'd0,  6'd0,  31};
    tbl[6] = '{2'b00, 2'b11, 5'd0, 6'd60, 5'd9, 6'd35, 1'b0, 1'b1, 6'd0,  6'd0,  31};
    tbl[7] = '{2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b0, 1'b1, 6'd0,  6'd0,  32};

    alloc_req = '0; commit_en = '0; commit_arch_rd = '0; commit_phys_rd = '0;
`ifdef FREELIST_ROLLBACK_EN
    flush = 1'b0;
`endif
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("table[%0d]", i));

    // Head is at slot 4; slots 4..31 still hold 36..63, then the freed 5, 7, 33, 9.
    for (int i = 0; i < 14; i++)
      run_vec(idle(2'b11, 1'b1, 6'(36 + 2*i), 6'(37 + 2*i), 32 - 2*i), $sformatf("drain[%0d]", i));
    run_vec(idle(2'b11, 1'b1, 6'd5,  6'd7, 4), "freed_5_then_7");
    run_vec(idle(2'b01, 1'b1, 6'd33, 6'd0, 2), "freed_33_after_7");
    run_vec(idle(2'b11, 1'b0, 6'd0,  6'd0, 1), "short_no_partial");
    run_vec(idle(2'b00, 1'b1, 6'd0,  6'd0, 1), "no_pop_when_short");
    run_vec(idle(2'b10, 1'b1, 6'd0,  6'd9, 1), "lane1_gets_9");
    run_vec(idle(2'b01, 1'b0, 6'd0,  6'd0, 0), "empty_not_ready");
    begin
      vec_t v;
      v = idle(2'b00, 1'b1, 6'd0, 6'd0, 0);
      v.cen = 2'b01; v.ar0 = 5'd0; v.pr0 = 6'd36;
      run_vec(v, "commit_x0_at_empty");
    end
    run_vec(idle(2'b00, 1'b1, 6'd0, 6'd0, 0), "x0_commit_frees_nothing");

    // Asynchronous reset with a request pending: state returns before any clock edge.
    rst = 1'b0;
    run_vec(idle(2'b11, 1'b1, 6'd32, 6'd33, 32), "async_reset_state");
    rst = 1'b1;
    run_vec(idle(2'b00, 1'b1, 6'd0, 6'd0, 32), "reset_dropped_request");

`ifdef FREELIST_ROLLBACK_EN
    do_reset();
    run_vec(idle(2'b11, 1'b1, 6'd32, 6'd33, 32), "rb_alloc_a");
    run_vec(idle(2'b11, 1'b1, 6'd34, 6'd35, 30), "rb_alloc_b");
    begin
      vec_t v;
      v = idle(2'b11, 1'b0, 6'd0, 6'd0, 28);
      v.cen = 2'b01; v.ar0 = 5'd3; v.pr0 = 6'd32; v.fl = 1'b1;
      run_vec(v, "rb_flush_with_commit");
    end
    run_vec(idle(2'b01, 1'b1, 6'd33, 6'd0, 32), "rb_head_rewound");
`endif

    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      vec_t v;
      int   cnt, k, arch, phys;
      int   ar[2], ph[2];
      v = idle(2'($urandom_range(0, 3)), 1'b0, 6'd0, 6'd0, 0);
      ar[0] = 0; ar[1] = 0; ph[0] = 0; ph[1] = 0;
      for (int l = 0; l < 2; l++) begin
        if (infl_m.size() > 0 && $urandom_range(0, 2) != 0) begin
          arch  = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 31));
          phys  = infl_m.pop_front();
          v.cen[l] = 1'b1;
          ar[l] = arch; ph[l] = phys;
        end
      end
      v.ar0 = 5'(ar[0]); v.pr0 = 6'(ph[0]); v.ar1 = 5'(ar[1]); v.pr1 = 6'(ph[1]);
      cnt   = int'(v.req[0]) + int'(v.req[1]);
      v.fc  = fl_m.size();
      v.rdy = (fl_m.size() >= cnt);
      if (v.rdy) begin
        k = 0;
        if (v.req[0]) begin v.a0 = 6'(fl_m[0]); k = 1; end
        if (v.req[1]) v.a1 = 6'(fl_m[k]);
        repeat (cnt) infl_m.push_back(fl_m.pop_front());
      end
      for (int l = 0; l < 2; l++) begin
        if (v.cen[l] && ar[l] != 0) begin
          fl_m.push_back(crat_m[ar[l]]);
          crat_m[ar[l]] = ph[l];
        end
      end
      run_vec(v, $sformatf("random[%0d]", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
